// File: rtl/inst_rom_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_ctrl_pkg
//  Purpose  : Shared widths, constant words and controller state encoding
//             for the instruction ROM controller and its byte packer.
//  Contents : INST_ADDR_W / INST_W bus widths, ZERO_WORD, NOP_INST,
//             rom_state_e (ROM_IDLE / ROM_LOAD / ROM_SERVE).
//  Revision : 1.0 - initial release
// ============================================================================
package inst_rom_ctrl_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;
   // addi x0, x0, 0
   localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0013;

   typedef enum logic [1:0] {
      ROM_IDLE  = 2'd0,
      ROM_LOAD  = 2'd1,
      ROM_SERVE = 2'd2
   } rom_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_rom_ctrl_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_ctrl_byte_packer
//  Purpose  : Packs a little-endian byte stream into 32-bit words and raises
//             a write strobe when a word is complete (4th byte) or when the
//             final byte of the program closes a partial word.
//  Ports    : clk, rst (async, active-low)
//             clear    - discard any partial word and restart at lane 0
//             accept   - a byte is being taken this cycle
//             byte_in  - the byte being taken
//             last     - the byte being taken is the final program byte
//             wr_en    - write wr_word this cycle
//             wr_word  - assembled word (unused upper lanes are zero)
//  Revision : 1.0 - initial release
// ============================================================================
module inst_rom_ctrl_byte_packer
   import inst_rom_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        byte_in,
   input  logic              last,
   output logic              wr_en,
   output logic [INST_W-1:0] wr_word
);

   logic [1:0]        lane;
   logic [INST_W-1:0] shift_reg;
   logic [INST_W-1:0] merged;
   logic              take;

   // A restart on the same cycle discards the incoming byte.
   assign take = accept & ~clear;

   // The accumulator is cleared after every written word, so lanes above the
   // current one are always zero: a last byte on a partial word is padded
   // with zeros for free.
   always_comb begin
      merged = shift_reg;
      merged[{lane, 3'b000} +: 8] = byte_in;
   end

   assign wr_en   = take & ((lane == 2'd3) | last);
   assign wr_word = merged;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane      <= 2'd0;
         shift_reg <= ZERO_WORD;
      end else if (clear) begin
         lane      <= 2'd0;
         shift_reg <= ZERO_WORD;
      end else if (take) begin
         if (wr_en) begin
            lane      <= 2'd0;
            shift_reg <= ZERO_WORD;
         end else begin
            lane      <= lane + 2'd1;
            shift_reg <= merged;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_rom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_ctrl
//  Purpose  : Instruction-fetch responder. Holds program words in an internal
//             array filled by a byte-stream loader, and returns one registered
//             word per fetch (1-cycle latency).
//  Ports    : clk, rst (async, active-low)
//             rom_ce_i / rom_addr_i  - fetch request (byte address)
//             rom_data_o             - fetched word, registered
//             load_start_i           - begin (or restart) a program load
//             load_valid_i / load_byte_i / load_last_i - byte stream
//             load_ready_o           - loader is taking bytes (LOAD state)
//             load_done_o            - one-cycle pulse after the last byte
//             load_ovf_o             - sticky: bytes dropped, array full
//             word_count_o           - words written by the last load
//  Revision : 1.0 - initial release
// ============================================================================
module inst_rom_ctrl
   import inst_rom_ctrl_pkg::*;
#(
   parameter int                DEPTH    = 1024,
   parameter int                AW       = 10,
   parameter logic [INST_W-1:0] NOP_WORD = NOP_INST
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rom_ce_i,
   input  logic [INST_ADDR_W-1:0] rom_addr_i,
   output logic [INST_W-1:0]      rom_data_o,
   input  logic                   load_start_i,
   input  logic                   load_valid_i,
   input  logic [7:0]             load_byte_i,
   input  logic                   load_last_i,
   output logic                   load_ready_o,
   output logic                   load_done_o,
   output logic                   load_ovf_o,
   output logic [AW:0]            word_count_o
);

   rom_state_e        state;
   rom_state_e        state_next;

   logic [INST_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic              full;
   logic              accept;
   logic              accept_last;
   logic              pk_wr_en;
   logic [INST_W-1:0] pk_word;
   logic              mem_we;
   logic [AW-1:0]     fetch_idx;
   logic              fetch_hit;

   assign load_ready_o = (state == ROM_LOAD);
   assign accept       = load_valid_i & load_ready_o;
   assign accept_last  = accept & load_last_i;

   // DEPTH = 2**AW, so the pointer reaches DEPTH exactly when its MSB sets.
   assign full   = wr_ptr[AW];
   assign mem_we = pk_wr_en & ~full;

   // ------------------------------------------------------------------
   // Controller state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ROM_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ROM_IDLE: begin
            if (load_start_i) state_next = ROM_LOAD;
         end
         ROM_LOAD: begin
            // A start on the same cycle as the last byte restarts the load.
            if (load_start_i)     state_next = ROM_LOAD;
            else if (accept_last) state_next = ROM_SERVE;
         end
         ROM_SERVE: begin
            if (load_start_i) state_next = ROM_LOAD;
         end
         default: state_next = ROM_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Byte packing
   // ------------------------------------------------------------------
   inst_rom_ctrl_byte_packer u_packer (
      .clk     (clk),
      .rst     (rst),
      .clear   (load_start_i),
      .accept  (accept),
      .byte_in (load_byte_i),
      .last    (load_last_i),
      .wr_en   (pk_wr_en),
      .wr_word (pk_word)
   );

   // ------------------------------------------------------------------
   // Write pointer, load status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         load_ovf_o   <= 1'b0;
         word_count_o <= '0;
         load_done_o  <= 1'b0;
      end else begin
         load_done_o <= accept_last & ~load_start_i;
         if (load_start_i) begin
            wr_ptr       <= '0;
            load_ovf_o   <= 1'b0;
            word_count_o <= '0;
         end else begin
            if (mem_we) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (accept && full) load_ovf_o <= 1'b1;
            // Include the word being written on this same cycle.
            if (accept_last) word_count_o <= mem_we ? wr_ptr + (AW+1)'(1) : wr_ptr;
         end
      end
   end

   // Program storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr[AW-1:0]] <= pk_word;
   end

   // ------------------------------------------------------------------
   // Fetch path
   // ------------------------------------------------------------------
   // addr < 4*word_count is the same as floor(addr/4) < word_count, and it
   // also rejects any address with bits above the array index set, since
   // word_count never exceeds DEPTH. The low two address bits only matter
   // through this compare; the index itself rounds misaligned fetches down.
   assign fetch_idx = rom_addr_i[AW+1:2];
   assign fetch_hit = rom_addr_i < INST_ADDR_W'({word_count_o, 2'b00});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_data_o <= ZERO_WORD;
      end else if (!rom_ce_i) begin
         rom_data_o <= ZERO_WORD;
      end else if ((state != ROM_SERVE) || !fetch_hit) begin
         rom_data_o <= NOP_WORD;
      end else begin
         rom_data_o <= mem[fetch_idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_rom_ctrl
//  Purpose  : Self-checking bench for inst_rom_ctrl (DEPTH=4) with a
//             behavioural reference model, directed scenarios and a
//             randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_rom_ctrl;

   localparam int          DEPTH = 4;
   localparam int          AW    = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        load_start_i;
   logic        load_valid_i;
   logic [7:0]  load_byte_i;
   logic        load_last_i;
   logic        load_ready_o;
   logic        load_done_o;
   logic        load_ovf_o;
   logic [AW:0] word_count_o;

   always #5 clk = ~clk;

   inst_rom_ctrl #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .NOP_WORD (NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rom_ce_i     (rom_ce_i),
      .rom_addr_i   (rom_addr_i),
      .rom_data_o   (rom_data_o),
      .load_start_i (load_start_i),
      .load_valid_i (load_valid_i),
      .load_byte_i  (load_byte_i),
      .load_last_i  (load_last_i),
      .load_ready_o (load_ready_o),
      .load_done_o  (load_done_o),
      .load_ovf_o   (load_ovf_o),
      .word_count_o (word_count_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a load is a list of bytes; on completion the words
   // are the bytes grouped by four (little-endian, zero padded), capped at
   // DEPTH words. Only completed loads are visible to fetches.
   // ------------------------------------------------------------------
   bit          m_loading;
   bit          m_serving;
   logic [7:0]  m_q[$];
   int          m_wc;
   bit          m_ovf;
   bit          m_done;
   logic [31:0] m_data;
   logic [31:0] m_mem [DEPTH];

   always @(posedge clk or negedge rst) begin : model
      logic [31:0] nd;
      logic [31:0] w;
      int          n;
      int          nw;
      if (!rst) begin
         m_loading = 0;
         m_serving = 0;
         m_q.delete();
         m_wc   = 0;
         m_ovf  = 0;
         m_done = 0;
         m_data = '0;
      end else begin
         if (!rom_ce_i)                               nd = '0;
         else if (!m_serving)                         nd = NOP;
         else if ((rom_addr_i / 4) < 32'(m_wc))       nd = m_mem[rom_addr_i / 4];
         else                                         nd = NOP;
         m_done = 0;
         if (load_start_i) begin
            m_loading = 1;
            m_serving = 0;
            m_q.delete();
            m_wc  = 0;
            m_ovf = 0;
         end else if (m_loading && load_valid_i) begin
            m_q.push_back(load_byte_i);
            if (m_q.size() > 4 * DEPTH) m_ovf = 1;
            if (load_last_i) begin
               n  = m_q.size();
               nw = (n + 3) / 4;
               if (nw > DEPTH) nw = DEPTH;
               for (int i = 0; i < nw; i++) begin
                  w = '0;
                  for (int j = 0; j < 4; j++)
                     if (4 * i + j < n) w[8*j +: 8] = m_q[4*i + j];
                  m_mem[i] = w;
               end
               m_wc      = nw;
               m_loading = 0;
               m_serving = 1;
               m_done    = 1;
            end
         end
         m_data = nd;
      end
   end

   bit chk_en = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_rom_data",   rom_data_o,          m_data);
         chk("model_ready",      32'(load_ready_o),   32'(m_loading));
         chk("model_done",       32'(load_done_o),    32'(m_done));
         chk("model_ovf",        32'(load_ovf_o),     32'(m_ovf));
         chk("model_word_count", 32'(word_count_o),   32'(m_wc));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers; every task starts and ends just after a falling edge.
   // ------------------------------------------------------------------
   logic [7:0] ld_q[$];

   task automatic idle_inputs();
      rom_ce_i     = 0;
      rom_addr_i   = '0;
      load_start_i = 0;
      load_valid_i = 0;
      load_byte_i  = '0;
      load_last_i  = 0;
   endtask

   task automatic start_load();
      load_start_i = 1;
      @(negedge clk);
      load_start_i = 0;
   endtask

   task automatic send_bytes(input int first, input int cnt, input bit gaps, input bit mark_last);
      for (int i = first; i < first + cnt; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            load_valid_i = 0;
            load_byte_i  = 8'($urandom);
            load_last_i  = 1;
            @(negedge clk);
         end
         load_valid_i = 1;
         load_byte_i  = ld_q[i];
         load_last_i  = mark_last && (i == ld_q.size() - 1);
         @(negedge clk);
      end
      load_valid_i = 0;
      load_last_i  = 0;
   endtask

   task automatic do_load(input bit gaps, input string nm);
      start_load();
      send_bytes(0, ld_q.size(), gaps, 1'b1);
      chk({nm, "_done_pulse"}, 32'(load_done_o), 32'd1);
      @(negedge clk);
      chk({nm, "_done_low"}, 32'(load_done_o), 32'd0);
   endtask

   task automatic fetch_chk(input logic ce, input logic [31:0] addr,
                            input logic [31:0] exp, input string nm);
      rom_ce_i   = ce;
      rom_addr_i = addr;
      @(negedge clk);
      rom_ce_i   = 0;
      chk(nm, rom_data_o, exp);
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("reset_data",  rom_data_o,           32'h0);
      chk("reset_ready", 32'(load_ready_o),    32'd0);
      chk("reset_wc",    32'(word_count_o),    32'd0);
      chk("reset_ovf",   32'(load_ovf_o),      32'd0);
      rst = 1;
      @(negedge clk);
      fetch_chk(1'b1, 32'h0, NOP,   "idle_fetch_nop");
      fetch_chk(1'b0, 32'h0, 32'h0, "idle_ce0_zero");

      // Two-instruction program
      ld_q = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      do_load(1'b0, "prog2");
      chk("prog2_wc", 32'(word_count_o), 32'd2);
      fetch_chk(1'b1, 32'h0, 32'h0010_0513, "prog2_w0");
      fetch_chk(1'b1, 32'h4, 32'h0020_0593, "prog2_w1");
      fetch_chk(1'b1, 32'h8, NOP,           "prog2_beyond");

      // Partial last word
      ld_q = {8'hAA, 8'hBB, 8'hCC};
      do_load(1'b0, "partial");
      chk("partial_wc", 32'(word_count_o), 32'd1);
      fetch_chk(1'b1, 32'h0, 32'h00CC_BBAA, "partial_w0");
      fetch_chk(1'b1, 32'h2, 32'h00CC_BBAA, "partial_misaligned");

      // Overflow: 20 bytes into a 4-word array
      ld_q.delete();
      for (int i = 0; i < 20; i++) ld_q.push_back(8'(i));
      do_load(1'b0, "ovf");
      chk("ovf_flag", 32'(load_ovf_o),   32'd1);
      chk("ovf_wc",   32'(word_count_o), 32'd4);
      fetch_chk(1'b1, 32'hC,  32'h0F0E_0D0C, "ovf_w3");
      fetch_chk(1'b1, 32'h10, NOP,           "ovf_out_of_range");
      fetch_chk(1'b1, 32'h8000_0000, NOP,    "ovf_high_addr");

      // Valid gaps, then back-to-back fetches
      ld_q = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      do_load(1'b1, "gaps");
      chk("gaps_ovf_clear", 32'(load_ovf_o), 32'd0);
      rom_ce_i = 1; rom_addr_i = 32'h0;
      @(negedge clk);
      rom_ce_i = 1; rom_addr_i = 32'h4;
      chk("b2b_w0", rom_data_o, 32'h0010_0513);
      @(negedge clk);
      rom_ce_i = 0; rom_addr_i = 32'($urandom);
      chk("b2b_w1", rom_data_o, 32'h0020_0593);
      @(negedge clk);
      rom_ce_i = 1; rom_addr_i = 32'h0;
      chk("b2b_ce0", rom_data_o, 32'h0);
      @(negedge clk);
      rom_ce_i = 0;
      chk("b2b_w0_again", rom_data_o, 32'h0010_0513);

      // Reset in the middle of a load
      rom_ce_i = 1; rom_addr_i = 32'h0;
      start_load();
      send_bytes(0, 5, 1'b0, 1'b0);
      #2 rst = 0;
      #1;
      chk("midrst_data",  rom_data_o,        32'h0);
      chk("midrst_ready", 32'(load_ready_o), 32'd0);
      chk("midrst_wc",    32'(word_count_o), 32'd0);
      rom_ce_i = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      fetch_chk(1'b1, 32'h0, NOP, "midrst_fetch_nop");
      do_load(1'b0, "fresh");
      chk("fresh_wc", 32'(word_count_o), 32'd2);
      fetch_chk(1'b1, 32'h4, 32'h0020_0593, "fresh_w1");

      // Randomized phase: the per-cycle compare against the model does the work
      for (int c = 0; c < 3000; c++) begin
         load_start_i = ($urandom_range(0, 49) == 0);
         load_valid_i = ($urandom_range(0, 2) != 0);
         load_byte_i  = 8'($urandom);
         load_last_i  = ($urandom_range(0, 15) == 0);
         rom_ce_i     = ($urandom_range(0, 3) != 0);
         rom_addr_i   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 23));
         @(negedge clk);
      end
      idle_inputs();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
